// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one SPI master between NUM_REQ clients and routes slave-select.
// Optional watchdog on the WAIT state is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_err,
    output logic [7:0]           m_tx_data,
    output logic                 m_start,
    input  logic                 m_done,
    input  logic [7:0]           m_rx_data,
    output logic [NUM_REQ-1:0]   ss_sel,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, GRANT, START, WAIT, RESP} state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     grant_q;
    logic [IDX_W-1:0]     last_grant_q;
    logic [NUM_REQ-1:0]   req_ready_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [7:0]           rsp_data_q;
    logic [7:0]           m_tx_data_q;
    logic                 m_start_q;
    logic [NUM_REQ-1:0]   ss_sel_q;

    logic [7:0]           req_byte [NUM_REQ];
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic [IDX_W-1:0]     cand;
    logic [NUM_REQ-1:0]   win_oh;
    logic [NUM_REQ-1:0]   grant_oh;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_byte
        assign req_byte[gi] = req_data[8*gi +: 8];
    end

    // Search starts just after the previous winner so the last winner has lowest priority.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_oh   = NUM_REQ'(1) << win_idx;
    assign grant_oh = NUM_REQ'(1) << grant_q;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            rsp_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            m_tx_data_q  <= '0;
            m_start_q    <= 1'b0;
            ss_sel_q     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_q         <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            m_start_q   <= 1'b0;
            case (state_q)
                // Grant-cycle outputs are loaded here so they are visible during GRANT.
                IDLE: begin
                    if (win_found) begin
                        state_q      <= GRANT;
                        grant_q      <= win_idx;
                        last_grant_q <= win_idx;
                        m_tx_data_q  <= req_byte[win_idx];
                        req_ready_q  <= win_oh;
                        ss_sel_q     <= win_oh;
                    end
                end
                GRANT: begin
                    state_q   <= START;
                    m_start_q <= 1'b1;
                end
                START: begin
                    state_q <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                end
                WAIT: begin
                    if (m_done) begin
                        state_q     <= RESP;
                        rsp_valid_q <= grant_oh;
                        rsp_data_q  <= m_rx_data;
                        ss_sel_q    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= grant_oh;
                        rsp_data_q  <= 8'h00;
                        rsp_err_q   <= 1'b1;
                        ss_sel_q    <= '0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
`endif
                    end
                end
                RESP: begin
                    state_q <= IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
                    rsp_err_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign m_tx_data = m_tx_data_q;
    assign m_start   = m_start_q;
    assign ss_sel    = ss_sel_q;
    assign busy      = (state_q != IDLE);
`ifdef SPI_ARB_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
